// File: rtl/decode_stage.sv
// Decode stage: turns a fetched RV32I/RV32M instruction into a registered
// control word, holds one entry, and inserts a bubble on a load-use hazard.

package rv32i_types;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SRA = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;

    localparam logic [2:0] CMP_BLT  = 3'b100;
    localparam logic [2:0] CMP_BLTU = 3'b110;

    localparam logic       MUX1_RS1 = 1'b0;
    localparam logic       MUX1_PC  = 1'b1;

    localparam logic [2:0] MUX2_I_IMM = 3'd0;
    localparam logic [2:0] MUX2_U_IMM = 3'd1;
    localparam logic [2:0] MUX2_B_IMM = 3'd2;
    localparam logic [2:0] MUX2_S_IMM = 3'd3;
    localparam logic [2:0] MUX2_J_IMM = 3'd4;
    localparam logic [2:0] MUX2_RS2   = 3'd5;

    localparam logic       CMPMUX_RS2   = 1'b0;
    localparam logic       CMPMUX_I_IMM = 1'b1;

    localparam logic [3:0] RF_ALU   = 4'd0;
    localparam logic [3:0] RF_BR_EN = 4'd1;
    localparam logic [3:0] RF_U_IMM = 4'd2;
    localparam logic [3:0] RF_LW    = 4'd3;
    localparam logic [3:0] RF_PC4   = 4'd4;
    localparam logic [3:0] RF_LB    = 4'd5;
    localparam logic [3:0] RF_LBU   = 4'd6;
    localparam logic [3:0] RF_LH    = 4'd7;
    localparam logic [3:0] RF_LHU   = 4'd8;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic        muldiv;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [2:0]  aluop;
        logic [2:0]  cmpop;
        logic        alumux1_sel;
        logic [2:0]  alumux2_sel;
        logic [3:0]  regfilemux_sel;
        logic        cmpmux_sel;
        logic        load_regfile;
        logic        use_rd;
        logic        mem_read;
        logic        mem_write;
        logic        br_sel;
        logic [31:0] instr;
        logic [31:0] pc;
    } rv32i_control_word;

endpackage

// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and offered data stays put until
// it is taken (or flushed).
module decode_stage
    import rv32i_types::*;
#(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 1,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              flush,
    input  logic              ex_load_valid,
    input  logic [4:0]        ex_load_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output rv32i_control_word ctrl_o,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]        state;
    rv32i_control_word dec;
    logic              bad;
    logic [6:0]        opcode;
    logic [6:0]        funct7;
    logic [2:0]        funct3;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic              rs1_used;
    logic              rs2_used;
    logic              hazard;
    logic              slot_free;
    logic              accept;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];
    assign funct7 = instr_i[31:25];

    // The upper immediate / jump offset occupies the rs1 field for these.
    assign rs1_used = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    assign rs2_used = (opcode == OP_REG) || (opcode == OP_BR) || (opcode == OP_STORE);

    assign hazard = in_valid && ex_load_valid && (ex_load_rd != 5'd0) &&
                    ((rs1_used && rs1 == ex_load_rd) || (rs2_used && rs2 == ex_load_rd));

    // The single entry can take a new instruction if it is empty or being drained now.
    assign slot_free = (state == S_EMPTY) || out_ready;
    assign in_ready  = !rst && !flush && !hazard && slot_free;
    assign accept    = in_valid && in_ready;

    // out_valid is the FSM state bit itself, so it doubles as the state probe.
    assign out_valid = (state == S_FULL);

    // Combinational decode of the offered instruction into a control word.
    always_comb begin
        bad                = 1'b0;
        dec                = '0;
        dec.valid          = 1'b1;
        dec.opcode         = opcode;
        dec.funct3         = funct3;
        dec.instr          = instr_i;
        dec.pc             = 32'(pc_i);
        dec.aluop          = funct3;
        dec.cmpop          = funct3;
        dec.use_rd         = 1'b1;
        dec.alumux1_sel    = MUX1_RS1;
        dec.alumux2_sel    = MUX2_I_IMM;
        dec.regfilemux_sel = RF_ALU;
        dec.cmpmux_sel     = CMPMUX_RS2;
        case (opcode)
            OP_LUI: begin
                dec.load_regfile   = 1'b1;
                dec.regfilemux_sel = RF_U_IMM;
            end
            OP_AUIPC: begin
                dec.load_regfile = 1'b1;
                dec.alumux1_sel  = MUX1_PC;
                dec.alumux2_sel  = MUX2_U_IMM;
                dec.aluop        = ALU_ADD;
            end
            OP_JAL: begin
                dec.load_regfile   = 1'b1;
                dec.alumux1_sel    = MUX1_PC;
                dec.alumux2_sel    = MUX2_J_IMM;
                dec.aluop          = ALU_ADD;
                dec.regfilemux_sel = RF_PC4;
                dec.br_sel         = 1'b1;
            end
            OP_JALR: begin
                dec.load_regfile   = 1'b1;
                dec.aluop          = ALU_ADD;
                dec.regfilemux_sel = RF_PC4;
                dec.br_sel         = 1'b1;
                bad                = (funct3 != 3'b000);
            end
            OP_BR: begin
                dec.alumux1_sel = MUX1_PC;
                dec.alumux2_sel = MUX2_B_IMM;
                dec.aluop       = ALU_ADD;
                dec.br_sel      = 1'b1;
                dec.use_rd      = 1'b0;
                bad             = (funct3[2:1] == 2'b01);
            end
            OP_LOAD: begin
                dec.load_regfile = 1'b1;
                dec.mem_read     = 1'b1;
                dec.aluop        = ALU_ADD;
                case (funct3)
                    3'b000:  dec.regfilemux_sel = RF_LB;
                    3'b001:  dec.regfilemux_sel = RF_LH;
                    3'b010:  dec.regfilemux_sel = RF_LW;
                    3'b100:  dec.regfilemux_sel = RF_LBU;
                    3'b101:  dec.regfilemux_sel = RF_LHU;
                    default: bad = 1'b1;
                endcase
            end
            OP_STORE: begin
                dec.mem_write   = 1'b1;
                dec.alumux2_sel = MUX2_S_IMM;
                dec.aluop       = ALU_ADD;
                dec.use_rd      = 1'b0;
                bad             = (funct3 > 3'd2);
            end
            OP_IMM: begin
                dec.load_regfile = 1'b1;
                case (funct3)
                    3'b010: begin
                        dec.cmpop          = CMP_BLT;
                        dec.cmpmux_sel     = CMPMUX_I_IMM;
                        dec.regfilemux_sel = RF_BR_EN;
                    end
                    3'b011: begin
                        dec.cmpop          = CMP_BLTU;
                        dec.cmpmux_sel     = CMPMUX_I_IMM;
                        dec.regfilemux_sel = RF_BR_EN;
                    end
                    3'b001:  bad = (funct7 != 7'h00);
                    3'b101: begin
                        if (funct7 == 7'h20) dec.aluop = ALU_SRA;
                        else if (funct7 != 7'h00) bad = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_REG: begin
                dec.load_regfile = 1'b1;
                dec.alumux2_sel  = MUX2_RS2;
                if (funct7 == 7'h00) begin
                    if (funct3 == 3'b010 || funct3 == 3'b011) begin
                        dec.cmpop          = (funct3 == 3'b010) ? CMP_BLT : CMP_BLTU;
                        dec.regfilemux_sel = RF_BR_EN;
                    end
                end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
                    dec.aluop = ALU_SUB;
                end else if (funct7 == 7'h20 && funct3 == 3'b101) begin
                    dec.aluop = ALU_SRA;
                end else if (funct7 == 7'h01 && ENABLE_M != 0) begin
                    dec.muldiv = 1'b1;
                end else begin
                    bad = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase
        // Illegal instructions still flow down the pipe, but with every side effect stripped.
        if (bad) begin
            dec.illegal      = 1'b1;
            dec.load_regfile = 1'b0;
            dec.mem_read     = 1'b0;
            dec.mem_write    = 1'b0;
            dec.br_sel       = 1'b0;
        end
    end

    // One-entry FSM and output register; flush beats everything, then accept, then drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_EMPTY;
            ctrl_o <= '0;
        end else if (flush) begin
            state <= S_EMPTY;
        end else if (accept) begin
            state  <= S_FULL;
            ctrl_o <= dec;
        end else if (slot_free) begin
            state <= S_EMPTY;
        end
    end

    // Count load-use bubbles, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (!flush && hazard && slot_free && bubble_cnt != '1) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one instance with M decode and a wide
// counter, one without M decode and a 2-bit counter, both on shared inputs.
module tb_decode_stage;
    import rv32i_types::*;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [31:0]       instr_i;
    logic [31:0]       pc_i;
    logic              flush;
    logic              ex_load_valid;
    logic [4:0]        ex_load_rd;
    logic              out_ready;

    logic              in_ready;
    logic              out_valid;
    rv32i_control_word ctrl_o;
    logic [31:0]       bubble_cnt;

    logic              nm_in_ready;
    logic              nm_out_valid;
    rv32i_control_word nm_ctrl;
    logic [1:0]        nm_bubble;

    int n_cmp;
    int n_bad;
    int exp_bub;

    decode_stage #(.XLEN(32), .ENABLE_M(1), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr_i(instr_i), .pc_i(pc_i), .flush(flush),
        .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
        .out_valid(out_valid), .out_ready(out_ready), .ctrl_o(ctrl_o),
        .bubble_cnt(bubble_cnt)
    );

    decode_stage #(.XLEN(32), .ENABLE_M(0), .CNT_W(2)) dut_nm (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nm_in_ready),
        .instr_i(instr_i), .pc_i(pc_i), .flush(flush),
        .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
        .out_valid(nm_out_valid), .out_ready(out_ready), .ctrl_o(nm_ctrl),
        .bubble_cnt(nm_bubble)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Illegal/legal decode table: instr, illegal, mem_read, mem_write, load_regfile
    logic [31:0] tbl_instr [10] = '{32'h0000307F, 32'h00003003, 32'h0000A103, 32'h00002063,
                                    32'h00003023, 32'h40109093, 32'h4010D093, 32'h00001067,
                                    32'h0000A023, 32'h40209133};
    logic [3:0]  tbl_exp   [10] = '{4'b1000, 4'b1000, 4'b0101, 4'b1000,
                                    4'b1000, 4'b1000, 4'b0001, 4'b1000,
                                    4'b0010, 4'b1000};

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_bub = 0;
        rst = 1'b1;
        in_valid = 1'b1;
        instr_i = 32'h40208133;
        pc_i = 32'h0;
        flush = 1'b0;
        ex_load_valid = 1'b0;
        ex_load_rd = 5'd0;
        out_ready = 1'b1;

        // Reset state, with an instruction already offered
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_ctrl_zero", 64'(ctrl_o == '0), 64'd1);
        check("rst_bubble", 64'(bubble_cnt), 64'd0);

        // sub x2,x1,x2 accepted on first edge after reset release
        rst = 1'b0;
        pc_i = 32'h100;
        #1;
        check("sub_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("sub_out_valid", 64'(out_valid), 64'd1);
        check("sub_aluop", 64'(ctrl_o.aluop), 64'd3);
        check("sub_load_rf", 64'(ctrl_o.load_regfile), 64'd1);
        check("sub_illegal", 64'(ctrl_o.illegal), 64'd0);
        check("sub_pc", 64'(ctrl_o.pc), 64'h100);
        check("sub_alumux2", 64'(ctrl_o.alumux2_sel), 64'd5);
        tick();
        check("drain_out_valid", 64'(out_valid), 64'd0);

        // Load-use hazard on add x6,x5,x5
        ex_load_valid = 1'b1;
        ex_load_rd = 5'd5;
        in_valid = 1'b1;
        instr_i = 32'h00528333;
        #1;
        check("hz_in_ready", 64'(in_ready), 64'd0);
        tick();
        exp_bub = 1;
        check("hz_out_valid", 64'(out_valid), 64'd0);
        check("hz_bubble", 64'(bubble_cnt), 64'(exp_bub));
        check("hz_nm_bubble", 64'(nm_bubble), 64'd1);
        ex_load_valid = 1'b0;
        #1;
        check("hz_clear_in_ready", 64'(in_ready), 64'd1);
        tick();
        check("hz_acc_out_valid", 64'(out_valid), 64'd1);
        check("hz_acc_instr", 64'(ctrl_o.instr), 64'h00528333);
        check("hz_acc_aluop", 64'(ctrl_o.aluop), 64'd0);

        // No hazard: rd x0, rs2 field of an I-type, rs1 field of lui
        ex_load_valid = 1'b1;
        ex_load_rd = 5'd0;
        instr_i = 32'h00000033;
        #1;
        check("nohz_rd0", 64'(in_ready), 64'd1);
        ex_load_rd = 5'd5;
        instr_i = 32'h00508393;
        #1;
        check("nohz_imm_rs2", 64'(in_ready), 64'd1);
        instr_i = 32'h000280B7;
        #1;
        check("nohz_lui_rs1", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        ex_load_valid = 1'b0;
        tick();

        // mul with and without M decode
        in_valid = 1'b1;
        instr_i = 32'h02B50533;
        tick();
        check("mul_muldiv", 64'(ctrl_o.muldiv), 64'd1);
        check("mul_load_rf", 64'(ctrl_o.load_regfile), 64'd1);
        check("mul_illegal", 64'(ctrl_o.illegal), 64'd0);
        check("mul_rfmux", 64'(ctrl_o.regfilemux_sel), 64'd0);
        check("nm_mul_valid", 64'(nm_out_valid), 64'd1);
        check("nm_mul_illegal", 64'(nm_ctrl.illegal), 64'd1);
        check("nm_mul_load_rf", 64'(nm_ctrl.load_regfile), 64'd0);
        check("nm_mul_muldiv", 64'(nm_ctrl.muldiv), 64'd0);

        // Back-pressure: or x3,x1,x2 held for 3 cycles
        instr_i = 32'h0020E1B3;
        pc_i = 32'h200;
        tick();
        out_ready = 1'b0;
        instr_i = 32'h00000013;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("st_out_valid", 64'(out_valid), 64'd1);
            check("st_instr", 64'(ctrl_o.instr), 64'h0020E1B3);
            check("st_aluop", 64'(ctrl_o.aluop), 64'd6);
            check("st_in_ready", 64'(in_ready), 64'd0);
        end
        flush = 1'b1;
        #1;
        check("fl_in_ready", 64'(in_ready), 64'd0);
        tick();
        check("fl_out_valid", 64'(out_valid), 64'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("fl_dropped", 64'(out_valid), 64'd0);
        check("fl_bubble", 64'(bubble_cnt), 64'(exp_bub));

        // Flush together with a hazard counts as flush only
        ex_load_valid = 1'b1;
        ex_load_rd = 5'd5;
        in_valid = 1'b1;
        instr_i = 32'h00528333;
        flush = 1'b1;
        #1;
        check("flhz_in_ready", 64'(in_ready), 64'd0);
        tick();
        check("flhz_bubble", 64'(bubble_cnt), 64'(exp_bub));
        check("flhz_out_valid", 64'(out_valid), 64'd0);
        flush = 1'b0;
        ex_load_valid = 1'b0;

        // Legal/illegal decode table, back-to-back
        for (int i = 0; i < 10; i++) begin
            instr_i = tbl_instr[i];
            tick();
            check("tbl_valid", 64'(out_valid), 64'd1);
            check("tbl_instr", 64'(ctrl_o.instr), 64'(tbl_instr[i]));
            check("tbl_illegal", 64'(ctrl_o.illegal), 64'(tbl_exp[i][3]));
            check("tbl_mem_read", 64'(ctrl_o.mem_read), 64'(tbl_exp[i][2]));
            check("tbl_mem_write", 64'(ctrl_o.mem_write), 64'(tbl_exp[i][1]));
            check("tbl_load_rf", 64'(ctrl_o.load_regfile), 64'(tbl_exp[i][0]));
            if (tbl_instr[i] == 32'h4010D093)
                check("tbl_srai_aluop", 64'(ctrl_o.aluop), 64'd2);
        end
        in_valid = 1'b0;
        tick();

        // Four bubbles in a row: wide counter counts, 2-bit counter saturates
        ex_load_valid = 1'b1;
        ex_load_rd = 5'd5;
        in_valid = 1'b1;
        instr_i = 32'h00528333;
        repeat (4) tick();
        exp_bub = exp_bub + 4;
        check("sat_bubble", 64'(bubble_cnt), 64'(exp_bub));
        check("sat_nm_bubble", 64'(nm_bubble), 64'd3);
        ex_load_valid = 1'b0;
        tick();
        check("sat_acc_valid", 64'(out_valid), 64'd1);

        // Hazard while FULL and stalled: no bubble is inserted
        out_ready = 1'b0;
        ex_load_valid = 1'b1;
        repeat (2) tick();
        check("stall_hz_bubble", 64'(bubble_cnt), 64'(exp_bub));
        check("stall_hz_valid", 64'(out_valid), 64'd1);

        // Asynchronous reset mid-FULL, checked before any edge
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_ctrl_zero", 64'(ctrl_o == '0), 64'd1);
        check("arst_bubble", 64'(bubble_cnt), 64'd0);
        check("arst_nm_bubble", 64'(nm_bubble), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd0);
        ex_load_valid = 1'b0;
        instr_i = 32'h40208133;
        out_ready = 1'b1;
        tick();
        check("arst_no_accept", 64'(out_valid), 64'd0);
        rst = 1'b0;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'd1);
        tick();
        check("rel_out_valid", 64'(out_valid), 64'd1);
        check("rel_aluop", 64'(ctrl_o.aluop), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
